// File: rtl/fifo_rd_pkg.sv
// fifo_rd_pkg: shared constants for the FIFO read-side streamer.
// Latency: n/a (constants only).
// Backpressure: n/a.
package fifo_rd_pkg;

  // Command FSM encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  // Output buffer depth; pops are allowed only while count < BUF_DEPTH
  localparam int BUF_DEPTH = 2;

endpackage

// File: rtl/rd_skid_buf.sv
// rd_skid_buf: 2-entry in-order buffer of {last, data} with registered outputs.
// Latency: a push into an empty buffer is visible on m_valid/m_data the next cycle.
// Backpressure: head holds stable while m_valid && !m_ready; caller must not push when count==2.
//
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   push/push_data/push_last  write side (one word per cycle)
//   m_valid/m_data/m_last/m_ready  head of buffer as a valid/ready stream
//   count               number of occupied entries (0..2)
module rd_skid_buf #(
  parameter int DSIZE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [DSIZE-1:0] push_data,
  input  logic             push_last,
  output logic             m_valid,
  output logic [DSIZE-1:0] m_data,
  output logic             m_last,
  input  logic             m_ready,
  output logic [1:0]       count
);

  // Second entry; the head lives directly in m_data/m_last so outputs are registered.
  logic [DSIZE-1:0] d1;
  logic             l1;
  logic [1:0]       cnt;
  logic             take;

  assign m_valid = (cnt != 2'd0);
  assign count   = cnt;
  assign take    = m_valid && m_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt    <= 2'd0;
      m_data <= '0;
      m_last <= 1'b0;
      d1     <= '0;
      l1     <= 1'b0;
    end else begin
      case ({push, take})
        2'b10: begin
          if (cnt == 2'd0) begin
            m_data <= push_data;
            m_last <= push_last;
          end else begin
            d1 <= push_data;
            l1 <= push_last;
          end
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          // With one entry the head becomes stale but m_valid drops with it.
          m_data <= d1;
          m_last <= l1;
          cnt    <= cnt - 2'd1;
        end
        2'b11: begin
          // Count unchanged: new word goes behind whatever is still queued.
          if (cnt == 2'd1) begin
            m_data <= push_data;
            m_last <= push_last;
          end else begin
            m_data <= d1;
            m_last <= l1;
            d1     <= push_data;
            l1     <= push_last;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: pops exactly len words from a FWFT FIFO and streams them out with m_last/done.
// Latency: rinc in cycle N -> m_valid in cycle N+1 (empty buffer); 1 word/cycle sustained.
// Backpressure: pops gated only by registered buffer count (no m_ready->rinc path); stalls on rempty.
//
// Ports:
//   rclk, rrst          read clock, synchronous active-low reset
//   rempty/rinc/rdata   FIFO read port (first-word fall-through)
//   start/len           command; sampled only when idle
//   busy/done           command in progress / one-cycle completion pulse
//   m_valid/m_data/m_last/m_ready  output stream
//   stall_cnt           present only when FIFO_RD_STALL_CNT_EN is defined:
//                       saturating count of RUN cycles starved by rempty
module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int DSIZE = 8,
  parameter int LSIZE = 8
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             rempty,
  output logic             rinc,
  input  logic [DSIZE-1:0] rdata,
  input  logic             start,
  input  logic [LSIZE-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             m_valid,
  output logic [DSIZE-1:0] m_data,
  output logic             m_last,
  input  logic             m_ready
`ifdef FIFO_RD_STALL_CNT_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  logic [1:0]       state;
  logic [LSIZE-1:0] remaining;
  logic [1:0]       count;
  logic             pop;
  logic             pop_last;

  assign pop      = (state == ST_RUN) && !rempty && (count < 2'(BUF_DEPTH)) && (remaining != '0);
  assign pop_last = (remaining == LSIZE'(1));
  assign rinc     = pop;
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge rclk) begin
    if (!rrst) begin
      state     <= ST_IDLE;
      remaining <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (len != '0) begin
              remaining <= len;
              state     <= ST_RUN;
            end else begin
              done <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (pop) begin
            remaining <= remaining - LSIZE'(1);
            if (pop_last) state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          // Only the last-tagged word ends the command; earlier words may still drain first.
          if (m_valid && m_ready && m_last) begin
            done  <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef FIFO_RD_STALL_CNT_EN
  always_ff @(posedge rclk) begin
    if (!rrst) begin
      stall_cnt <= '0;
    end else if (state == ST_IDLE && start) begin
      stall_cnt <= '0;
    end else if (state == ST_RUN && rempty && (count < 2'(BUF_DEPTH)) && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

  rd_skid_buf #(.DSIZE(DSIZE)) u_buf (
    .clk       (rclk),
    .rst       (rrst),
    .push      (pop),
    .push_data (rdata),
    .push_last (pop_last),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_last    (m_last),
    .m_ready   (m_ready),
    .count     (count)
  );

endmodule

// File: tb/tb_fifo_rd_stream.sv
module tb_fifo_rd_stream;

  logic       rclk = 1'b0;
  logic       rrst;
  logic       rempty;
  logic       rinc;
  logic [7:0] rdata;
  logic       start;
  logic [7:0] len;
  logic       busy, done, m_valid, m_last, m_ready;
  logic [7:0] m_data;
`ifdef FIFO_RD_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  always #5 rclk = ~rclk;

  fifo_rd_stream #(.DSIZE(8), .LSIZE(8)) dut (
    .rclk    (rclk),
    .rrst    (rrst),
    .rempty  (rempty),
    .rinc    (rinc),
    .rdata   (rdata),
    .start   (start),
    .len     (len),
    .busy    (busy),
    .done    (done),
    .m_valid (m_valid),
    .m_data  (m_data),
    .m_last  (m_last),
    .m_ready (m_ready)
`ifdef FIFO_RD_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // FIFO contents seen by the DUT, and the reference model of the command
  logic [7:0] fifo_q[$];
  logic [8:0] outq[$];     // {last, data} words popped but not yet accepted downstream
  int         mph  = 0;    // 0 idle, 1 popping, 2 waiting for last word to drain
  int         left = 0;
  logic       mdone = 1'b0;
  int         mstall = 0;
  logic       chk_en = 1'b0;

  // observations of the last cycle
  logic       obs_rinc, obs_done, obs_hs;
  logic [7:0] got[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: present FIFO state, compare DUT against the model, advance the model.
  task automatic cycle();
    logic e_rinc, e_mv, hs, e_ml;
    logic [7:0] e_md;
    int ph0, sz0;
    logic [7:0] w;
    rempty = (fifo_q.size() == 0);
    rdata  = rempty ? 8'($urandom) : fifo_q[0];
    ph0    = mph;
    sz0    = outq.size();
    e_mv   = (sz0 > 0);
    e_md   = e_mv ? outq[0][7:0] : 8'h00;
    e_ml   = e_mv ? outq[0][8] : 1'b0;
    e_rinc = (ph0 == 1) && !rempty && (sz0 < 2) && (left != 0);
    #1;
    if (chk_en) begin
      check("rinc", rinc, e_rinc);
      check("m_valid", m_valid, e_mv);
      check("busy", busy, ph0 != 0);
      check("done", done, mdone);
      if (e_mv) begin
        check("m_data", m_data, e_md);
        check("m_last", m_last, e_ml);
      end
`ifdef FIFO_RD_STALL_CNT_EN
      check("stall_cnt", stall_cnt, mstall);
`endif
    end
    obs_rinc = rinc;
    obs_done = done;
    obs_hs   = m_valid && m_ready;
    if (obs_hs) got.push_back(m_data);
    hs    = e_mv && m_ready;
    mdone = 1'b0;
    if (!rrst) begin
      if (e_rinc) void'(fifo_q.pop_front());  // word is lost
      mph = 0; left = 0; outq.delete(); mstall = 0;
    end else begin
      if (ph0 == 1 && rempty && sz0 < 2 && mstall < 65535) mstall++;
      if (ph0 == 2 && hs && outq[0][8]) begin
        mdone = 1'b1;
        mph   = 0;
      end
      if (hs) void'(outq.pop_front());
      if (e_rinc) begin
        w = fifo_q.pop_front();
        outq.push_back({left == 1, w});
        left--;
        if (left == 0) mph = 2;
      end
      if (ph0 == 0 && start) begin
        mstall = 0;
        if (len != 0) begin
          left = len;
          mph  = 1;
        end else begin
          mdone = 1'b1;
        end
      end
    end
    @(posedge rclk);
    @(negedge rclk);
  endtask

  // Runs until done is seen; records cycle indices (1 = first cycle of this call).
  int r_first, r_last, r_nrinc, r_lasths, r_done;
  task automatic run_to_done(input int max, input string nm);
    r_first = -1; r_last = -1; r_nrinc = 0; r_lasths = -1; r_done = -1;
    for (int i = 1; i <= max; i++) begin
      cycle();
      if (obs_rinc) begin
        if (r_first < 0) r_first = i;
        r_last = i;
        r_nrinc++;
      end
      if (obs_hs) r_lasths = i;
      if (obs_done) begin
        r_done = i;
        break;
      end
    end
    if (r_done < 0) check({nm, "_timeout"}, 0, 1);
  endtask

  initial begin
    int l;
    int n;
    rrst = 1'b0; start = 1'b0; len = 8'd0; m_ready = 1'b0;
    rempty = 1'b0; rdata = 8'h00;

    // Reset with a non-empty FIFO: nothing may pop
    fifo_q.push_back(8'h77);
    cycle();
    chk_en = 1'b1;
    cycle();
    check("rst_busy", busy, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_last", m_last, 0);
    check("rst_fifo_untouched", fifo_q.size(), 1);
    fifo_q.delete();
    rrst = 1'b1;
    cycle();

    // Basic transfer
    fifo_q = '{8'h11, 8'h22, 8'h33};
    m_ready = 1'b1; got.delete();
    start = 1'b1; len = 8'd3;
    cycle();
    start = 1'b0;
    run_to_done(20, "basic");
    check("basic_first_rinc", r_first, 1);
    check("basic_last_rinc", r_last, 3);
    check("basic_nrinc", r_nrinc, 3);
    check("basic_last_hs", r_lasths, 4);
    check("basic_done", r_done, 5);
    check("basic_cnt", got.size(), 3);
    if (got.size() == 3) begin
      check("basic_w0", got[0], 8'h11);
      check("basic_w1", got[1], 8'h22);
      check("basic_w2", got[2], 8'h33);
    end

    // Backpressure
    fifo_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    m_ready = 1'b0; got.delete();
    start = 1'b1; len = 8'd4;
    cycle();
    start = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (obs_rinc) n++;
      if (i >= 1) check("bp_hold", m_data, 8'h01);
    end
    check("bp_pops", n, 2);
    m_ready = 1'b1;
    run_to_done(20, "bp");
    check("bp_cnt", got.size(), 4);
    for (int i = 0; i < got.size() && i < 4; i++) check("bp_word", got[i], 8'(i + 1));

    // Underrun
    got.delete();
    start = 1'b1; len = 8'd2;
    cycle();
    start = 1'b0;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (obs_rinc) n++;
    end
    check("ur_no_pop", n, 0);
    check("ur_busy", busy, 1);
`ifdef FIFO_RD_STALL_CNT_EN
    check("ur_stall5", stall_cnt, 5);
`endif
    fifo_q = '{8'hA5, 8'h5A};
    run_to_done(20, "ur");
    check("ur_cnt", got.size(), 2);
    if (got.size() == 2) begin
      check("ur_w0", got[0], 8'hA5);
      check("ur_w1", got[1], 8'h5A);
    end

    // Zero length
    start = 1'b1; len = 8'd0;
    cycle();
    start = 1'b0;
    cycle();
    check("zl_done", obs_done, 1);
    check("zl_rinc", obs_rinc, 0);

    // Start while busy is ignored
    fifo_q = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
    got.delete();
    start = 1'b1; len = 8'd3;
    cycle();
    cycle();
    len = 8'd7;
    cycle();
    start = 1'b0;
    run_to_done(20, "ign");
    check("ign_cnt", got.size(), 3);
    check("ign_fifo_left", fifo_q.size(), 2);
    fifo_q.delete();

    // Reset mid-command
    fifo_q = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5};
    m_ready = 1'b1;
    start = 1'b1; len = 8'd5;
    cycle();
    start = 1'b0;
    cycle();
    cycle();
    rrst = 1'b0;
    cycle();
    rrst = 1'b1;
    n = fifo_q.size();
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("mr_busy", busy, 0);
      check("mr_valid", m_valid, 0);
      check("mr_rinc", rinc, 0);
    end
    check("mr_fifo_kept", fifo_q.size(), n);
    fifo_q.delete();

    // Randomized commands
    for (int c = 0; c < 40; c++) begin
      got.delete();
      l = $urandom_range(0, 12);
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) fifo_q.push_back(8'($urandom));
      start = 1'b1; len = 8'(l); m_ready = $urandom_range(0, 1);
      cycle();
      start = 1'b0;
      for (int k = 0; k < 400 && (mph != 0 || mdone); k++) begin
        m_ready = ($urandom_range(0, 9) < 7);
        if ($urandom_range(0, 9) < 6) fifo_q.push_back(8'($urandom));
        if (mph != 0 && $urandom_range(0, 19) == 0) begin
          start = 1'b1; len = 8'($urandom);
        end else begin
          start = 1'b0;
        end
        cycle();
      end
      start = 1'b0;
      if (mph != 0) check("rand_timeout", 0, 1);
      check("rand_len", got.size(), l);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
